// File: rtl/branch_cmp_seq.sv
// Multi-cycle RV64 branch-condition sequencer.
// Compares operands one slice per cycle, MSB slice first.
module branch_cmp_seq #(
  parameter int XLEN  = 64,
  parameter int SLICE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic            taken,
  output logic            illegal
);

  localparam int NS = XLEN / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [2:0]      f3;
  logic [KW-1:0]   k;
  logic            lt;
  logic            eq;
  logic            res_v;
  logic            ill_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic             slice_eq;
  logic             slice_lt;
  logic             signed_cmp;
  logic             f3_bad;
  logic             accept;
  logic             dec;

  always_comb begin
    a_s = op_a[int'(k)*SLICE +: SLICE];
    b_s = op_b[int'(k)*SLICE +: SLICE];
  end

  // Only the top slice of a BLT/BGE carries the sign.
  assign signed_cmp = (k == K_TOP) && (f3[2:1] == 2'b10);
  assign slice_eq   = (a_s == b_s);
  assign slice_lt   = signed_cmp ? ($signed(a_s) < $signed(b_s))
                                 : (a_s < b_s);
  assign f3_bad     = (f3[2:1] == 2'b01);
  assign accept     = start && (state != S_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      f3    <= '0;
      k     <= '0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      res_v <= 1'b0;
      ill_q <= 1'b0;
    end else if (accept) begin
      state <= S_CMP;
      op_a  <= rs1;
      op_b  <= rs2;
      f3    <= funct3;
      k     <= K_TOP;
      lt    <= 1'b0;
      eq    <= 1'b0;
      res_v <= 1'b0;
      ill_q <= 1'b0;
    end else if (state == S_CMP) begin
      if (f3_bad) begin
        ill_q <= 1'b1;
        state <= S_DONE;
      end else if (slice_eq && (k != '0)) begin
        k <= k - 1'b1;
      end else begin
        eq    <= slice_eq;
        lt    <= !slice_eq && slice_lt;
        res_v <= 1'b1;
        state <= S_DONE;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end

  // Decision is a pure function of latched registers, so it is stable.
  always_comb begin
    dec = 1'b0;
    unique case (1'b1)
      (f3 == 3'b000):     dec = eq;
      (f3 == 3'b001):     dec = !eq;
      (f3[2] && !f3[0]):  dec = lt;
      (f3[2] && f3[0]):   dec = !lt;
      default:            dec = 1'b0;
    endcase
  end

  assign busy    = (state == S_CMP);
  assign done    = (state == S_DONE);
  assign taken   = res_v && dec;
  assign illegal = ill_q;

endmodule
